// File: rtl/usb_tx_pkg.sv
// Shared types and line encodings for the USB full-speed TX line encoder.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_enc_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int STUFF_LIMIT_DEF  = 6;
    localparam int EOP_SE0_BITS_DEF = 2;

    function automatic logic [1:0] nrzi_flip(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_bit_stuffer.sv
// Run-length counter of transmitted ones; raises stuff_now when the
// next bit slot must carry a stuffed zero.
module usb_tx_bit_stuffer #(
    parameter int STUFF_LIMIT = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic bit_en,
    input  logic bit_val,
    input  logic clear,
    output logic stuff_now
);

    localparam int CW = $clog2(STUFF_LIMIT + 1);

    logic [CW-1:0] ones;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones <= '0;
        end else if (clear) begin
            ones <= '0;
        end else if (bit_en) begin
            ones <= bit_val ? ones + CW'(1) : '0;
        end
    end

    assign stuff_now = (ones == CW'(STUFF_LIMIT));

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB FS TX serializer: byte buffering, bit stuffing, NRZI, EOP.
// Define USB_TX_SYNC_GEN_EN to emit the SYNC byte internally.
module usb_tx_line_encoder #(
    parameter int STUFF_LIMIT  = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       bit_en_TX,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       dp_out,
    output logic       dm_out,
    output logic       tx_done,
    output logic       tx_underrun
);

    import usb_tx_pkg::*;

    localparam int SW = $clog2(EOP_SE0_BITS + 1);

    tx_enc_state_t state, state_nxt;

    logic [1:0]    line_q, line_nxt;
    logic [7:0]    sreg, sreg_nxt;
    logic [2:0]    bit_cnt, cnt_nxt;
    logic [7:0]    hold, hold_nxt;
    logic          hold_valid, hv_nxt;
    logic          hold_last, hl_nxt;
    logic          cur_last, cl_nxt;
    logic [SW-1:0] se0_cnt, se0_nxt;
    logic          done_q, done_nxt;
    logic          und_q, und_nxt;

    logic          accept;
    logic          in_bits;
    logic          in_eop;
    logic          stuff_now;
    logic          stf_en;
    logic          stf_val;
    logic          stf_clr;
    logic [7:0]    src_data;
    logic          src_last;

    assign in_bits  = (state == ST_SYNC) || (state == ST_DATA);
    assign in_eop   = (state == ST_EOP_SE0) || (state == ST_EOP_J);
    assign tx_ready = !hold_valid && !in_eop;
    assign accept   = tx_valid && tx_ready;

    // A stuff bit still owed at end of data is sent from EOP_SE0.
    assign stf_en  = bit_en_TX &&
                     (in_bits || (state == ST_EOP_SE0 && stuff_now));
    assign stf_val = !stuff_now && sreg[0];
    assign stf_clr = (state == ST_IDLE) || (state == ST_EOP_J);

    usb_tx_bit_stuffer #(
        .STUFF_LIMIT(STUFF_LIMIT)
    ) u_stuffer (
        .clk      (clk),
        .n_rst    (n_rst),
        .bit_en   (stf_en),
        .bit_val  (stf_val),
        .clear    (stf_clr),
        .stuff_now(stuff_now)
    );

    assign src_data = hold_valid ? hold : tx_data;
    assign src_last = hold_valid ? hold_last : tx_last;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            line_q     <= LINE_J;
            sreg       <= '0;
            bit_cnt    <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
            cur_last   <= 1'b0;
            se0_cnt    <= '0;
            done_q     <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            line_q     <= line_nxt;
            sreg       <= sreg_nxt;
            bit_cnt    <= cnt_nxt;
            hold       <= hold_nxt;
            hold_valid <= hv_nxt;
            hold_last  <= hl_nxt;
            cur_last   <= cl_nxt;
            se0_cnt    <= se0_nxt;
            done_q     <= done_nxt;
            und_q      <= und_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        line_nxt  = line_q;
        sreg_nxt  = sreg;
        cnt_nxt   = bit_cnt;
        hold_nxt  = hold;
        hv_nxt    = hold_valid;
        hl_nxt    = hold_last;
        cl_nxt    = cur_last;
        se0_nxt   = se0_cnt;
        done_nxt  = 1'b0;
        und_nxt   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (hold_valid || accept) begin
                    cnt_nxt = '0;
`ifdef USB_TX_SYNC_GEN_EN
                    sreg_nxt  = SYNC_BYTE;
                    cl_nxt    = 1'b0;
                    hold_nxt  = src_data;
                    hv_nxt    = 1'b1;
                    hl_nxt    = src_last;
                    state_nxt = ST_SYNC;
`else
                    sreg_nxt  = src_data;
                    cl_nxt    = src_last;
                    hv_nxt    = 1'b0;
                    state_nxt = ST_DATA;
`endif
                end
            end

            ST_SYNC, ST_DATA: begin
                if (bit_en_TX) begin
                    if (stuff_now) begin
                        line_nxt = nrzi_flip(line_q);
                    end else begin
                        if (!sreg[0]) begin
                            line_nxt = nrzi_flip(line_q);
                        end
                        sreg_nxt = {1'b0, sreg[7:1]};
                        cnt_nxt  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (cur_last) begin
                                state_nxt = ST_EOP_SE0;
                                se0_nxt   = '0;
                            end else if (hold_valid) begin
                                sreg_nxt  = hold;
                                cl_nxt    = hold_last;
                                hv_nxt    = 1'b0;
                                state_nxt = ST_DATA;
                            end else begin
                                und_nxt   = 1'b1;
                                state_nxt = ST_EOP_SE0;
                                se0_nxt   = '0;
                            end
                        end
                    end
                end
            end

            ST_EOP_SE0: begin
                if (bit_en_TX) begin
                    if (stuff_now) begin
                        line_nxt = nrzi_flip(line_q);
                    end else if (int'(se0_cnt) < EOP_SE0_BITS) begin
                        line_nxt = LINE_SE0;
                        se0_nxt  = se0_cnt + SW'(1);
                    end else begin
                        line_nxt  = LINE_J;
                        state_nxt = ST_EOP_J;
                    end
                end
            end

            ST_EOP_J: begin
                if (bit_en_TX) begin
                    line_nxt  = LINE_J;
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                line_nxt  = LINE_J;
            end
        endcase

        // Refill after any shifter load above, so a same-edge accept is kept.
        if (accept && state != ST_IDLE) begin
            hold_nxt = tx_data;
            hv_nxt   = 1'b1;
            hl_nxt   = tx_last;
        end
    end

    assign dp_out      = line_q[1];
    assign dm_out      = line_q[0];
    assign tx_active   = (state != ST_IDLE);
    assign tx_done     = done_q;
    assign tx_underrun = und_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Testbench for usb_tx_line_encoder: symbol-level model of the USB line.
// Builds the expected dp/dm sequence per packet and compares every cycle.
module tb_usb_tx_line_encoder;

    localparam logic [1:0] LJ = 2'b10;
    localparam logic [1:0] LK = 2'b01;
    localparam logic [1:0] LS = 2'b00;

    typedef struct packed {
        logic [1:0] sym;
        logic       done;
        logic       und;
        logic       eb;
    } ent_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       bit_en_TX;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_active;
    logic       dp_out;
    logic       dm_out;
    logic       tx_done;
    logic       tx_underrun;

    int   n_chk = 0;
    int   n_err = 0;
    bit   skip = 1'b1;
    bit   stretch = 1'b0;
    bit   active_exp = 1'b0;
    bit   in_eop = 1'b0;
    ent_t exp_q[$];
    logic [7:0] pay[$];

    usb_tx_line_encoder dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bit_en_TX  (bit_en_TX),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .tx_active  (tx_active),
        .dp_out     (dp_out),
        .dm_out     (dm_out),
        .tx_done    (tx_done),
        .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] flip(input logic [1:0] s);
        return (s == LJ) ? LK : LJ;
    endfunction

    function automatic ent_t mk(input logic [1:0] s, input logic d,
                                input logic u, input logic e);
        ent_t r;
        r.sym  = s;
        r.done = d;
        r.und  = u;
        r.eb   = e;
        return r;
    endfunction

    // Expected line symbols, one per bit time after acceptance.
    task automatic build_model(input bit has_last);
        logic [1:0] lvl;
        logic [7:0] b;
        int ones;
        int nb;
        bit x;
        bit endb;
        lvl  = LJ;
        ones = 0;
        nb   = pay.size() + 1;
        for (int i = 0; i < nb; i++) begin
            b = (i == 0) ? 8'h80 : pay[i-1];
            for (int k = 0; k < 8; k++) begin
                x    = b[k];
                endb = (i == nb - 1) && (k == 7);
                if (!x) lvl = flip(lvl);
                exp_q.push_back(mk(lvl, 1'b0, endb && !has_last, endb));
                ones = x ? ones + 1 : 0;
                if (ones == 6) begin
                    lvl = flip(lvl);
                    exp_q.push_back(mk(lvl, 1'b0, 1'b0, 1'b0));
                    ones = 0;
                end
            end
        end
        exp_q.push_back(mk(LS, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(LS, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(LJ, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(LJ, 1'b1, 1'b0, 1'b0));
    endtask

    // Irregular 7/8/7 strobe cadence, optionally stretched.
    initial begin
        int g;
        bit_en_TX = 1'b0;
        @(negedge clk);
        forever begin
            for (int p = 0; p < 3; p++) begin
                g = (p == 1) ? 8 : 7;
                if (stretch && $urandom_range(0, 3) == 0)
                    g += $urandom_range(1, 25);
                repeat (g - 1) @(negedge clk);
                bit_en_TX = 1'b1;
                @(negedge clk);
                bit_en_TX = 1'b0;
            end
        end
    end

    always @(posedge clk) begin : mon
        logic       acc_s;
        logic       stb_s;
        logic       act_s;
        logic [1:0] pl;
        ent_t       e;
        acc_s = tx_valid && tx_ready;
        stb_s = bit_en_TX;
        act_s = active_exp;
        pl    = {dp_out, dm_out};
        #1;
        if (n_rst && !skip) begin
            if (act_s && stb_s) begin
                check("bits_left", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("line", {dp_out, dm_out}, e.sym);
                    check("tx_done", tx_done, e.done);
                    check("tx_underrun", tx_underrun, e.und);
                    if (e.eb) in_eop = 1'b1;
                    if (e.done) begin
                        active_exp = 1'b0;
                        in_eop     = 1'b0;
                    end
                end
            end else begin
                check("line_hold", {dp_out, dm_out}, pl);
                check("done_quiet", tx_done, 0);
                check("und_quiet", tx_underrun, 0);
            end
            if (acc_s && !act_s) active_exp = 1'b1;
            check("tx_active", tx_active, active_exp);
            if (!active_exp) begin
                check("idle_line", {dp_out, dm_out}, LJ);
                check("idle_ready", tx_ready, 1);
            end
            if (in_eop) check("eop_ready", tx_ready, 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit l);
        int n;
        tx_data  = b;
        tx_last  = l;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", n < 3000, 1);
        @(negedge clk);
    endtask

    task automatic send_bytes(input bit has_last);
        logic [7:0] sq[$];
        sq = pay;
`ifndef USB_TX_SYNC_GEN_EN
        sq.push_front(8'h80);
`endif
        for (int i = 0; i < sq.size(); i++)
            send_byte(sq[i], has_last && (i == sq.size() - 1));
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("packet_finished", exp_q.size() == 0, 1);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            active_exp = 1'b0;
            in_eop     = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_pkt(input bit has_last);
        build_model(has_last);
        send_bytes(has_last);
        wait_done();
    endtask

    initial begin
        logic [1:0] pin0[19];
        logic [7:0] rb;
        int len;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = 8'h00;
        n_rst    = 1'b1;
        #1 n_rst = 1'b0;
        #3;
        check("rst_dp", dp_out, 1);
        check("rst_dm", dm_out, 0);
        check("rst_active", tx_active, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_done", tx_done, 0);
        check("rst_und", tx_underrun, 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        skip  = 1'b0;

        // Hand-derived symbols pin the model.
        pin0 = '{LK, LJ, LK, LJ, LK, LJ, LK, LK,
                 LJ, LK, LJ, LK, LJ, LK, LJ, LK,
                 LS, LS, LJ};
        pay = '{8'h00};
        build_model(1'b1);
        check("pin0_len", exp_q.size(), 20);
        for (int i = 0; i < 19; i++)
            check("pin0_sym", exp_q[i].sym, pin0[i]);
        check("pin0_done", exp_q[19].done, 1);
        exp_q.delete();

        pay = '{8'hFF};
        build_model(1'b1);
        check("pin1_len", exp_q.size(), 21);
        check("pin1_k5", exp_q[12].sym, LK);
        check("pin1_stuff", exp_q[13].sym, LJ);
        check("pin1_tail", exp_q[16].sym, LJ);
        check("pin1_eb", exp_q[16].eb, 1);
        exp_q.delete();

        pay = '{8'hFC};
        build_model(1'b0);
        check("pin2_len", exp_q.size(), 21);
        check("pin2_last", exp_q[15].sym, LK);
        check("pin2_und", exp_q[15].und, 1);
        check("pin2_stuff", exp_q[16].sym, LJ);
        exp_q.delete();

        pay = '{8'h00};
        run_pkt(1'b1);
        pay = '{8'hFF};
        run_pkt(1'b1);
        pay = '{8'hA5, 8'h3C, 8'hC3};
        run_pkt(1'b1);
        pay = '{8'hFC};
        run_pkt(1'b1);
        pay = '{8'h12, 8'h34};
        run_pkt(1'b0);
        pay = '{8'hFC};
        run_pkt(1'b0);

        // Abort mid-packet with asynchronous reset.
        skip = 1'b1;
        pay = '{8'hFF, 8'h55};
        send_bytes(1'b1);
        repeat (25) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("abort_dp", dp_out, 1);
        check("abort_dm", dm_out, 0);
        check("abort_active", tx_active, 0);
        check("abort_ready", tx_ready, 1);
        @(negedge clk);
        exp_q.delete();
        active_exp = 1'b0;
        in_eop     = 1'b0;
        n_rst      = 1'b1;
        @(negedge clk);
        skip = 1'b0;
        pay = '{8'h5A, 8'h01};
        run_pkt(1'b1);

        stretch = 1'b1;
        for (int p = 0; p < 12; p++) begin
            pay.delete();
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                rb = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                pay.push_back(rb);
            end
            run_pkt($urandom_range(0, 4) != 0);
        end
        stretch = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
